// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: word alignment via bit-slip requests, control-token detection
// and 8b data decode. Define TMDS_DECODER_ERR_EN to add transition-error flagging and counting.
module tmds_decoder #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int MAX_GAP        = 4096,
  parameter int SLIP_WAIT      = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  symbol_in,
  input  logic        symbol_valid_in,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de_out,
  output logic        valid_out,
  output logic        locked_out,
  output logic        bitslip_out
`ifdef TMDS_DECODER_ERR_EN
  ,
  output logic        err_out,
  output logic [15:0] err_count_out
`endif
);

  localparam int TOK_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int TO_W   = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int GAP_W  = $clog2(MAX_GAP) + 1;
  localparam int SLIP_W = $clog2(SLIP_WAIT) + 1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [9:0]        sym_p1_d, sym_p1_q;
  logic              is_ctrl_p1_d, is_ctrl_p1_q;
  logic [1:0]        ctrl_p1_d, ctrl_p1_q;
  logic              vld_p1_d, vld_p1_q;

  logic [7:0]        data_p2_d, data_p2_q;
  logic [1:0]        ctrl_p2_d, ctrl_p2_q;
  logic              de_p2_d, de_p2_q;
  logic              vld_p2_d, vld_p2_q;

  state_t            state_d, state_q;
  logic [TOK_W-1:0]  tok_cnt_d, tok_cnt_q;
  logic [TO_W-1:0]   to_cnt_d, to_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_d, gap_cnt_q;
  logic [SLIP_W-1:0] slip_cnt_d, slip_cnt_q;
  logic              locked_d, locked_q;
  logic              bitslip_d, bitslip_q;

  // Returns {is_ctrl, c1, c0}.
  function automatic logic [2:0] classify(input logic [9:0] s);
    case (s)
      10'b1101010100: return 3'b1_00;
      10'b0010101011: return 3'b1_01;
      10'b0101010100: return 3'b1_10;
      10'b1010101011: return 3'b1_11;
      default:        return 3'b0_00;
    endcase
  endfunction

  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] q;
    d    = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

`ifdef TMDS_DECODER_ERR_EN
  logic        err_p2_d, err_p2_q;
  logic [15:0] err_cnt_d, err_cnt_q;

  function automatic logic [3:0] transitions(input logic [9:0] s);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'b000, s[i] ^ s[i+1]};
    end
    return n;
  endfunction
`endif

  // Stage 1: capture symbol and classify it
  always_comb begin
    vld_p1_d     = symbol_valid_in;
    sym_p1_d     = sym_p1_q;
    is_ctrl_p1_d = is_ctrl_p1_q;
    ctrl_p1_d    = ctrl_p1_q;
    if (symbol_valid_in) begin
      sym_p1_d                  = symbol_in;
      {is_ctrl_p1_d, ctrl_p1_d} = classify(symbol_in);
    end
  end

  // Alignment FSM works on the stage-1 classification
  always_comb begin
    state_d    = state_q;
    tok_cnt_d  = tok_cnt_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    slip_cnt_d = slip_cnt_q;
    bitslip_d  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vld_p1_q) begin
          tok_cnt_d = is_ctrl_p1_q ? tok_cnt_q + 1'b1 : '0;
          if (tok_cnt_d == TOK_W'(LOCK_TOKENS)) begin
            state_d   = ST_LOCKED;
            tok_cnt_d = '0;
            to_cnt_d  = '0;
            gap_cnt_d = '0;
          end else if (to_cnt_q == TO_W'(SEARCH_TIMEOUT - 1)) begin
            state_d    = ST_SLIP;
            bitslip_d  = 1'b1;
            tok_cnt_d  = '0;
            to_cnt_d   = '0;
            slip_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        if (slip_cnt_q == SLIP_W'(SLIP_WAIT - 1)) begin
          state_d    = ST_SEARCH;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (vld_p1_q) begin
          if (is_ctrl_p1_q) begin
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_d == GAP_W'(MAX_GAP)) begin
              state_d   = ST_SEARCH;
              gap_cnt_d = '0;
              tok_cnt_d = '0;
              to_cnt_d  = '0;
            end
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // Stage 2: decoded outputs
  always_comb begin
    vld_p2_d  = vld_p1_q;
    data_p2_d = data_p2_q;
    ctrl_p2_d = ctrl_p2_q;
    de_p2_d   = de_p2_q;
    if (vld_p1_q) begin
      de_p2_d = ~is_ctrl_p1_q;
      if (is_ctrl_p1_q) ctrl_p2_d = ctrl_p1_q;
      else              data_p2_d = decode_data(sym_p1_q);
    end
  end

`ifdef TMDS_DECODER_ERR_EN
  always_comb begin
    err_p2_d  = vld_p1_q && !is_ctrl_p1_q && (state_q == ST_LOCKED)
                && (transitions(sym_p1_q) >= 4'd6);
    err_cnt_d = err_cnt_q;
    if (err_out && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clk_in) begin
    sym_p1_q     <= sym_p1_d;
    is_ctrl_p1_q <= is_ctrl_p1_d;
    ctrl_p1_q    <= ctrl_p1_d;
    if (rst_in) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      ctrl_p2_q  <= '0;
      de_p2_q    <= 1'b0;
      state_q    <= ST_SEARCH;
      tok_cnt_q  <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      slip_cnt_q <= '0;
      locked_q   <= 1'b0;
      bitslip_q  <= 1'b0;
`ifdef TMDS_DECODER_ERR_EN
      err_p2_q   <= 1'b0;
      err_cnt_q  <= '0;
`endif
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      ctrl_p2_q  <= ctrl_p2_d;
      de_p2_q    <= de_p2_d;
      state_q    <= state_d;
      tok_cnt_q  <= tok_cnt_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      locked_q   <= locked_d;
      bitslip_q  <= bitslip_d;
`ifdef TMDS_DECODER_ERR_EN
      err_p2_q   <= err_p2_d;
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  // In-flight symbols are dropped as soon as lock is lost.
  assign valid_out   = vld_p2_q & locked_q;
  assign data_out    = data_p2_q;
  assign ctrl_out    = ctrl_p2_q;
  assign de_out      = de_p2_q;
  assign locked_out  = locked_q;
  assign bitslip_out = bitslip_q;
`ifdef TMDS_DECODER_ERR_EN
  assign err_out       = err_p2_q & valid_out;
  assign err_count_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: stimulus pushes expected outputs, a monitor pops on valid_out.
module tb_tmds_decoder;

  localparam logic [9:0] T0  = 10'b1101010100;
  localparam logic [9:0] T3  = 10'b1010101011;
  localparam logic [9:0] ROT = 10'b1001101010;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [9:0]  symbol_in;
  logic        symbol_valid_in;
  logic [7:0]  data_out;
  logic [1:0]  ctrl_out;
  logic        de_out;
  logic        valid_out;
  logic        locked_out;
  logic        bitslip_out;
`ifdef TMDS_DECODER_ERR_EN
  logic        err_out;
  logic [15:0] err_count_out;
`endif

  typedef struct {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   slip_cnt = 0;
  int   slip_cyc[8];
  logic prev_bs = 1'b0;

  tmds_decoder #(
    .LOCK_TOKENS(8), .SEARCH_TIMEOUT(16), .MAX_GAP(32), .SLIP_WAIT(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .symbol_in(symbol_in),
    .symbol_valid_in(symbol_valid_in),
    .data_out(data_out),
    .ctrl_out(ctrl_out),
    .de_out(de_out),
    .valid_out(valid_out),
    .locked_out(locked_out),
    .bitslip_out(bitslip_out)
`ifdef TMDS_DECODER_ERR_EN
    ,
    .err_out(err_out),
    .err_count_out(err_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [9:0] s, input logic v);
    symbol_in       = s;
    symbol_valid_in = v;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(10'h000, 1'b0);
  endtask

  task automatic push(input logic de, input logic [1:0] ctrl, input logic [7:0] data,
                      input logic err);
    exp_t e;
    e.de = de; e.ctrl = ctrl; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk_in) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data=%0h ctrl=%0h de=%0b with nothing expected",
                 data_out, ctrl_out, de_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_de", de_out, mon_e.de);
        chk("out_ctrl", ctrl_out, mon_e.ctrl);
        if (mon_e.de) chk("out_data", data_out, mon_e.data);
`ifdef TMDS_DECODER_ERR_EN
        chk("out_err", err_out, mon_e.err);
`endif
      end
    end
    if (bitslip_out) begin
      chk("bitslip_single_cycle", prev_bs, 1'b0);
      chk("bitslip_not_locked", locked_out, 1'b0);
      if (slip_cnt < 8) slip_cyc[slip_cnt] = cyc;
      slip_cnt++;
    end
    prev_bs = bitslip_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_in = 1'b1;
    symbol_in = '0;
    symbol_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("rst_data", data_out, 8'h00);
    chk("rst_ctrl", ctrl_out, 2'b00);
    chk("rst_de", de_out, 1'b0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_locked", locked_out, 1'b0);
    chk("rst_bitslip", bitslip_out, 1'b0);
`ifdef TMDS_DECODER_ERR_EN
    chk("rst_err", err_out, 1'b0);
    chk("rst_err_count", err_count_out, 16'h0000);
`endif

    // Lock on 8 consecutive c=00 tokens
    for (int i = 0; i < 7; i++) send(T0, 1'b1);
    push(1'b0, 2'b00, 8'h00, 1'b0);
    send(T0, 1'b1);
    chk("lock_not_yet", locked_out, 1'b0);
    idle(1);
    chk("lock_rise", locked_out, 1'b1);
    idle(2);

    // Data decode and control update
    push(1'b1, 2'b00, 8'h00, 1'b0); send(10'h100, 1'b1);
    push(1'b1, 2'b00, 8'hFE, 1'b0); send(10'h2FF, 1'b1);
    push(1'b0, 2'b11, 8'h00, 1'b0); send(T3, 1'b1);
    push(1'b1, 2'b11, 8'hFF, 1'b1); send(10'h155, 1'b1);
    push(1'b1, 2'b11, 8'h44, 1'b0); send(10'h3C3, 1'b1);
    idle(4);
`ifdef TMDS_DECODER_ERR_EN
    chk("err_count_1", err_count_out, 16'd1);
`endif
    push(1'b1, 2'b11, 8'h01, 1'b1); send(10'h2AA, 1'b1);
    idle(4);
`ifdef TMDS_DECODER_ERR_EN
    chk("err_count_2", err_count_out, 16'd2);
`endif
    chk("decode_drained", exp_q.size(), 0);

    // Loss of lock after MAX_GAP data symbols without a token
    push(1'b0, 2'b00, 8'h00, 1'b0); send(T0, 1'b1);
    for (int i = 0; i < 31; i++) begin
      push(1'b1, 2'b00, 8'h00, 1'b0);
      send(10'h100, 1'b1);
    end
    idle(1);
    chk("gap_31_locked", locked_out, 1'b1);
    send(10'h100, 1'b1);
    idle(1);
    chk("gap_loss_locked", locked_out, 1'b0);
    chk("gap_loss_valid", valid_out, 1'b0);
    chk("gap_loss_no_slip", slip_cnt, 0);
    idle(20);
    chk("gap_loss_no_slip_later", slip_cnt, 0);

    // Reset while locked with data in flight
    for (int i = 0; i < 7; i++) send(T0, 1'b1);
    push(1'b0, 2'b00, 8'h00, 1'b0);
    send(T0, 1'b1);
    idle(1);
    chk("relock", locked_out, 1'b1);
    push(1'b0, 2'b11, 8'h00, 1'b0); send(T3, 1'b1);
    push(1'b1, 2'b11, 8'hFF, 1'b1); send(10'h155, 1'b1);
    send(10'h3C3, 1'b1);
    rst_in = 1'b1;
    send(10'h000, 1'b0);
    rst_in = 1'b0;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_ctrl", ctrl_out, 2'b00);
    chk("midrst_de", de_out, 1'b0);
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_locked", locked_out, 1'b0);
    chk("midrst_bitslip", bitslip_out, 1'b0);
`ifdef TMDS_DECODER_ERR_EN
    chk("midrst_err", err_out, 1'b0);
    chk("midrst_err_count", err_count_out, 16'h0000);
`endif
    idle(4);
    chk("midrst_drained", exp_q.size(), 0);

    // Misaligned stream: slips every 16 symbols + 4 wait cycles
    n = 0;
    while (slip_cnt < 3 && n < 200) begin
      send(ROT, 1'b1);
      n++;
    end
    chk("slip_three_seen", (slip_cnt >= 3), 1'b1);
    if (slip_cnt >= 3) begin
      chk("slip_period_1", slip_cyc[1] - slip_cyc[0], 20);
      chk("slip_period_2", slip_cyc[2] - slip_cyc[1], 20);
    end
    chk("slip_not_locked", locked_out, 1'b0);
    idle(6);
    for (int i = 0; i < 7; i++) send(T0, 1'b1);
    push(1'b0, 2'b00, 8'h00, 1'b0);
    send(T0, 1'b1);
    idle(1);
    chk("realign_lock", locked_out, 1'b1);
    idle(3);

    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side TMDS channel decoder. Consumes raw 10-bit symbols from one per-channel deserializer, aligns the word boundary by requesting bit slips until control tokens appear regularly, and undoes DC-balance inversion and transition-minimization coding. Outputs are 8-bit pixel data, 2-bit control values and a data-enable flag. One instance sits per TMDS channel between the deserializer and the video-timing recovery logic.

## Interface
- LOCK_TOKENS, 8: consecutive control tokens required to enter LOCKED.
- SEARCH_TIMEOUT, 1024: valid symbols in SEARCH without lock before a bit slip is requested.
- MAX_GAP, 4096: valid symbols in LOCKED without any control token before lock is dropped.
- SLIP_WAIT, 4: cycles to ignore input after a bit-slip pulse.
- clk_in  input  1  pixel-rate clock; the only clock.
- rst_in  input  1  reset, synchronous, active-high.
- symbol_in  input  10  raw symbol, bit 0 first on the wire.
- symbol_valid_in  input  1  symbol_in valid this cycle.
- data_out  output  8  decoded pixel byte.
- ctrl_out  output  2  {c1,c0} from the most recent control token; held during data periods.
- de_out  output  1  1 = data symbol, 0 = control token.
- valid_out  output  1  outputs valid; asserted only while locked.
- locked_out  output  1  alignment FSM is in LOCKED.
- bitslip_out  output  1  one-cycle request to the deserializer to shift its boundary by one bit.

## Operation
- Control tokens:
  - 10'b1101010100 gives c=00.
  - 10'b0010101011 gives c=01.
  - 10'b0101010100 gives c=10.
  - 10'b1010101011 gives c=11.
  - Any other symbol is a data symbol.
- Data decode:
  - d = symbol[9] ? ~symbol[7:0] : symbol[7:0].
  - data[0] = d[0].
  - For i = 1..7: data[i] = symbol[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states SEARCH, SLIP, LOCKED. Reset enters SEARCH.
- SEARCH:
  - Each valid control token increments tok_cnt; each valid data symbol clears it.
  - When tok_cnt reaches LOCK_TOKENS, go to LOCKED.
  - Each valid symbol increments to_cnt. When to_cnt reaches SEARCH_TIMEOUT−1 without lock, pulse bitslip_out, clear both counters and go to SLIP.
- SLIP: wait SLIP_WAIT cycles regardless of input, then return to SEARCH.
- LOCKED:
  - gap_cnt counts valid symbols since the last control token; a control token clears it.
  - When gap_cnt reaches MAX_GAP, go to SEARCH with all counters cleared. No bit slip is issued on loss.
- Invalid input cycles: symbol_valid_in=0 advances no counter and produces no output.
- Widths: all counters are $clog2 of their limit plus 1 bit, and none wraps.
- ctrl_out resets to 2'b00 and updates only on a decoded control token.

## Timing
- Latency 2 cycles: the stage-1 register captures the symbol and its classification; the stage-2 register holds the decoded outputs.
- valid_out = stage-2 valid AND locked_out, evaluated at output time. Symbols still in flight when lock is lost are suppressed.
- locked_out rises the cycle after the LOCK_TOKENS-th token is registered. The token that completes lock appears on the outputs with valid_out=1.
- bitslip_out is high exactly one cycle per slip. It is never high in consecutive cycles and never high in LOCKED.
- Reset value of every output is 0, including data_out, ctrl_out, de_out, valid_out, locked_out and bitslip_out.
- Reset asserted mid-operation: the next cycle behaves as after power-up. Pipeline valid bits clear and the FSM enters SEARCH.
- A control token at the exact count where timeout fires: the token is counted first. Lock wins if it completes LOCK_TOKENS; otherwise the slip proceeds.

## Configuration
- TMDS_DECODER_ERR_EN defined:
  - Adds err_out (1-bit output, 1-cycle pulse aligned with valid_out) and err_count_out (16-bit output, saturating at 16'hFFFF, cleared by reset).
  - An error is a data symbol received in LOCKED with 6 or more adjacent-bit transitions across symbol[9:0].
- TMDS_DECODER_ERR_EN undefined: neither port exists and no error logic is built. All other behaviour is identical.

## Test plan
- Lock: reset, then 8 valid 10'b1101010100 -> locked_out=1 after the 8th token is registered; valid_out=1, de_out=0, ctrl_out=00 two cycles after that token.
- Decode: locked, symbols 10'h100 then 10'h2FF -> data_out 8'h00 then 8'hFE with de_out=1, each 2 cycles later. Then 10'b1010101011 -> de_out=0, ctrl_out=11.
- Misaligned stream: feed tokens rotated by 3 bits with SEARCH_TIMEOUT=16 -> bitslip_out pulses every 16 valid symbols plus SLIP_WAIT cycles. Re-aligning the stream in the bench after the 3rd slip -> lock follows.
- Loss: locked with MAX_GAP=32, feed 32 data symbols and no tokens -> locked_out=0 and valid_out=0 from the gap-limit cycle; bitslip_out stays 0.
- Reset mid-stream: assert rst_in for 1 cycle while LOCKED with data in flight -> all outputs 0 the next cycle and no stale valid_out.
- With TMDS_DECODER_ERR_EN defined, locked, symbol 10'b1010101010 -> err_out pulses once and err_count_out increments by 1.
